// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter: shares one SDRAM burst-read port between a video and a CPU-ROM requester.
// Video has fixed priority; the CPU-ROM side is forced through after STARVE_LIMIT consecutive video grants.
module sdram_read_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk_sys_99_287,
    input  logic        reset_n,

    input  logic        v_req,
    input  logic [24:0] v_addr,
    input  logic [7:0]  v_len,
    output logic        v_ack,
    output logic [15:0] v_data,
    output logic        v_data_valid,
    output logic        v_done,

    input  logic        c_req,
    input  logic [24:0] c_addr,
    input  logic [7:0]  c_len,
    output logic        c_ack,
    output logic [15:0] c_data,
    output logic        c_data_valid,
    output logic        c_done,

    output logic        sd_rd,
    output logic [24:0] sd_rd_addr,
    input  logic        sd_data_available,
    input  logic [15:0] sd_out,
    output logic        sd_end_burst,

    output logic        busy,
    output logic        timeout_err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BURST,
        END
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            owner_c;
    logic [7:0]      len_q;
    logic [8:0]      word_cnt;
    logic [IW-1:0]   idle_cnt;
    logic [SW-1:0]   starve_cnt;

    logic            grant;
    logic            grant_c;
    logic            strobe;
    logic            last_word;
    logic            idle_expired;

    // Grant is held off while reset is asserted so the first ack lands on a released edge.
    always_comb begin
        grant        = reset_n && (state == IDLE) && (v_req || c_req);
        grant_c      = c_req && (!v_req || (starve_cnt == STARVE_MAX));
        strobe       = (state == BURST) && sd_data_available;
        last_word    = strobe && (word_cnt == {1'b0, len_q});
        idle_expired = (state == BURST) && !sd_data_available && (idle_cnt == IDLE_LAST);
    end

    always_ff @(posedge clk_sys_99_287) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        v_ack        = 1'b0;
        c_ack        = 1'b0;
        sd_rd        = 1'b0;
        sd_end_burst = 1'b0;
        v_done       = 1'b0;
        c_done       = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = ISSUE;
                    v_ack     = !grant_c;
                    c_ack     = grant_c;
                end
            end
            ISSUE: begin
                sd_rd     = 1'b1;
                state_nxt = BURST;
            end
            BURST: begin
                if (last_word || idle_expired) begin
                    state_nxt = END;
                end
            end
            END: begin
                sd_end_burst = 1'b1;
                v_done       = !owner_c;
                c_done       = owner_c;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The latched request address doubles as sd_rd_addr, so it holds until the next grant.
    always_ff @(posedge clk_sys_99_287) begin
        if (!reset_n) begin
            owner_c      <= 1'b0;
            len_q        <= 8'd0;
            sd_rd_addr   <= 25'd0;
            word_cnt     <= 9'd0;
            idle_cnt     <= '0;
            starve_cnt   <= '0;
            timeout_err  <= 1'b0;
            v_data       <= 16'd0;
            v_data_valid <= 1'b0;
            c_data       <= 16'd0;
            c_data_valid <= 1'b0;
        end else begin
            v_data_valid <= strobe && !owner_c;
            c_data_valid <= strobe && owner_c;
            if (strobe && !owner_c) begin
                v_data <= sd_out;
            end
            if (strobe && owner_c) begin
                c_data <= sd_out;
            end

            if (grant) begin
                owner_c     <= grant_c;
                sd_rd_addr  <= grant_c ? c_addr : v_addr;
                len_q       <= grant_c ? c_len : v_len;
                word_cnt    <= 9'd0;
                idle_cnt    <= '0;
                timeout_err <= 1'b0;
                if (grant_c) begin
                    starve_cnt <= '0;
                end else if (c_req && (starve_cnt != STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (strobe) begin
                word_cnt <= word_cnt + 9'd1;
                idle_cnt <= '0;
            end else if (state == BURST) begin
                if (idle_expired) begin
                    timeout_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule
